ex_result_skid: RTL
===================

Name: ex_result_skid

Overview:
- Registered output stage for the EX-stage ALU. It captures the 64-bit result of the bitwise and arithmetic units, together with the destination-register tag and write enable, and hands them to the EX/MEM boundary.
- A 2-entry skid buffer (main entry M, skid entry S) absorbs one-cycle back-pressure from MEM, so ALU issue never needs a combinational ready path.
- It also produces a registered zero flag for branch resolution.

Parameters:
- WIDTH, 64, result datapath width in bits
- TAGW, 5, destination register tag width

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush (branch mispredict); discards all held entries
- in_valid  input  1  ALU result valid
- in_ready  output  1  stage can accept; registered, equals ~S_valid
- in_result  input  WIDTH  ALU result (e.g. A & B)
- in_rd  input  TAGW  destination register tag
- in_wen  input  1  register-file write enable for this result
- out_valid  output  1  M_valid
- out_ready  input  1  MEM stage accepts
- out_result  output  WIDTH  M result
- out_rd  output  TAGW  M tag
- out_wen  output  1  M write enable
- out_zero  output  1  1 when out_result == 0; registered together with M
- occupancy  output  2  number of held entries: 0, 1 or 2

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n = 0, all flops clear asynchronously.
  - Reset values: out_valid=0, in_ready=1, out_result=0, out_rd=0, out_wen=0, out_zero=1, occupancy=0, S cleared.
  - Reset asserted mid-operation drops all entries immediately; no partial transfer survives.
- Handshake events:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Producer and consumer rules:
  - The producer holds in_* stable while in_valid=1 and in_ready=0.
  - out_* stay stable while out_valid=1 and out_ready=0.
- States, encoded by occupancy: EMPTY(0), ONE(1), TWO(2). All transitions occur on the rising clk edge.
  - EMPTY:
    - in_fire -> ONE, M <= in.
    - else stay EMPTY.
  - ONE:
    - in_fire and out_fire -> ONE, M <= in.
    - out_fire only -> EMPTY.
    - in_fire only -> TWO, S <= in, M held.
    - neither -> stay ONE.
  - TWO:
    - in_ready=0, so in_fire is impossible.
    - out_fire -> ONE, M <= S, S cleared.
    - else hold.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted at edge N is visible on out_* after edge N.
  - Throughput is 1 beat/cycle while out_ready=1.
- Zero flag: out_zero is computed from the value being loaded into M, registered in the same edge as M. It is never computed combinationally from out_result.
- Flush:
  - flush=1 at an edge -> next state EMPTY, out_valid=0, in_ready=1.
  - Flush overrides any simultaneous in_fire or out_fire; a beat presented with flush is discarded.
  - out_fire in the flush cycle still counts as delivered to MEM; MEM owns squash of that beat.
- Data registers are not cleared when entries empty, except on reset. Only valid-qualified outputs are meaningful.
- Ordering: strict FIFO order. No beat is duplicated or lost except by flush or reset.
- Width rules:
  - out_result is a straight copy of in_result; no arithmetic is applied.
  - out_zero is the NOR reduction of all WIDTH bits.

Test Plan:
1. Reset pulse (rst_n low 2 cycles, asynchronous to clk) -> out_valid=0, in_ready=1, occupancy=0, out_zero=1, all during reset.
2. Streaming with out_ready=1: in_result = 0xFFFF0000FFFF0000, then 0x0, then 0x123 on consecutive cycles.
   - Same values appear one cycle later.
   - out_zero = 0,1,0 respectively.
   - occupancy stays 1 throughout.
3. Back-pressure: out_ready=0, push 0xAA (rd=3) then 0xBB (rd=4).
   - occupancy=2, in_ready=0; a third beat 0xCC is held off.
   - Raise out_ready: outputs deliver 0xAA, 0xBB, 0xCC in order with tags 3, 4, then 0xCC's tag.
4. Flush with occupancy=2 while in_valid=1 (0xDD) -> next cycle occupancy=0, out_valid=0, in_ready=1, and 0xDD never appears.
5. Simultaneous in_fire and out_fire in ONE (M=0x1, new 0x0) -> occupancy stays 1, out_result=0x0, out_zero=1.
6. Random valid/ready scoreboard, 10k cycles -> no loss, duplication or reordering, and occupancy always matches (beats accepted − beats delivered).

Source files
------------

// File: rtl/ex_result_skid.sv
// ---------------------------------------------------------------------------
// ex_result_skid
//
// Registered output stage for the EX-stage ALU. It captures the ALU result,
// the destination register tag and the write enable, and hands them across
// the EX/MEM boundary. A two-entry skid buffer absorbs back-pressure from MEM:
//   M : main entry, always the one presented on out_*
//   S : skid entry, filled only when M is occupied and MEM stalls
// Because in_ready is a decode of registered state, the ALU issue logic
// never sees a combinational path from out_ready.
// A zero flag for branch resolution is computed from the value written into
// M and registered together with it.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset, clears every flop
//   flush       synchronous flush, drops all held entries
//   in_valid    ALU result valid
//   in_ready    stage can accept (low only when both entries are full)
//   in_result   ALU result, WIDTH bits
//   in_rd       destination register tag, TAGW bits
//   in_wen      register-file write enable
//   out_valid   M holds a beat
//   out_ready   MEM accepts the beat in M
//   out_result  result held in M
//   out_rd      tag held in M
//   out_wen     write enable held in M
//   out_zero    1 when out_result is all zeros
//   occupancy   number of held entries: 0, 1 or 2
// ---------------------------------------------------------------------------
module ex_result_skid #(
    parameter int WIDTH = 64,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [TAGW-1:0]  in_rd,
    input  logic             in_wen,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAGW-1:0]  out_rd,
    output logic             out_wen,
    output logic             out_zero,
    output logic [1:0]       occupancy
);

    // The state encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Entry registers (one register stage past the ALU).
    logic [WIDTH-1:0] m_result_p1, s_result_p1;
    logic [TAGW-1:0]  m_rd_p1, s_rd_p1;
    logic             m_wen_p1, s_wen_p1;
    logic             m_zero_p1;

    // Datapath controls from the state machine.
    logic             load_m_in;
    logic             load_m_s;
    logic             load_s_in;

    logic             in_fire;
    logic             out_fire;

    // Value about to be written into M and its zero flag.
    logic [WIDTH-1:0] m_result_nx;
    logic [TAGW-1:0]  m_rd_nx;
    logic             m_wen_nx;

    function automatic logic all_zero(input logic [WIDTH-1:0] v);
        return ~|v;
    endfunction

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s_in = 1'b0;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d   = ONE;
                    load_m_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_m_in = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end else if (in_fire) begin
                    // M is stalled, so the new beat parks in S behind it.
                    state_d   = TWO;
                    load_s_in = 1'b1;
                end
            end
            TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (out_fire) begin
                    state_d  = ONE;
                    load_m_s = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush wins over any handshake in the same cycle; the incoming beat
        // is dropped and nothing is moved between entries.
        if (flush) begin
            state_d   = EMPTY;
            load_m_in = 1'b0;
            load_m_s  = 1'b0;
            load_s_in = 1'b0;
        end
    end

    always_comb begin
        m_result_nx = in_result;
        m_rd_nx     = in_rd;
        m_wen_nx    = in_wen;
        if (load_m_s) begin
            m_result_nx = s_result_p1;
            m_rd_nx     = s_rd_p1;
            m_wen_nx    = s_wen_p1;
        end
    end

    // -----------------------------------------------------------------------
    // Register stage: state, M and S entries
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Entry data is only rewritten on a load; emptied entries keep stale
    // contents, which is harmless because out_valid qualifies them.
    // S is considered empty purely from the state, so a TWO->ONE move does
    // not need to touch the S data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_result_p1 <= '0;
            m_rd_p1     <= '0;
            m_wen_p1    <= 1'b0;
            m_zero_p1   <= 1'b1;
            s_result_p1 <= '0;
            s_rd_p1     <= '0;
            s_wen_p1    <= 1'b0;
        end else begin
            if (load_m_in || load_m_s) begin
                m_result_p1 <= m_result_nx;
                m_rd_p1     <= m_rd_nx;
                m_wen_p1    <= m_wen_nx;
                m_zero_p1   <= all_zero(m_result_nx);
            end
            if (load_s_in) begin
                s_result_p1 <= in_result;
                s_rd_p1     <= in_rd;
                s_wen_p1    <= in_wen;
            end
        end
    end

    assign out_result = m_result_p1;
    assign out_rd     = m_rd_p1;
    assign out_wen    = m_wen_p1;
    assign out_zero   = m_zero_p1;

endmodule
